// File: rtl/commit_trace_sink.sv
// commit_trace_sink
//   Receiving end of the CPU commit interface in the simulation top. Each
//   retired instruction is queued in a FIFO and drained to the host over a
//   valid/ready port. Also keeps retire/cycle counters, stops on the halt
//   instruction, and flags a hung pipeline through a no-commit watchdog.
//   It never backpressures the CPU; records that do not fit are dropped
//   and counted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   commit, commit_instr,
//   commit_pc, commit_pre_pc retire strobe and payload from the CPU
//   trace_valid/ready/data   head-of-FIFO record {instr, pre_pc, pc}
//   instret                  accepted commits (dropped ones included)
//   cycles                   clocks spent in RUN
//   drop_cnt, overflow       saturating drop count, sticky drop flag
//   halted, timeout          terminal-state indicators
module commit_trace_sink #(
    parameter int          DEPTH          = 16,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] HALT_INSTR     = 32'h00100073
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         commit,
    input  logic [31:0]  commit_instr,
    input  logic [63:0]  commit_pc,
    input  logic [63:0]  commit_pre_pc,
    output logic         trace_valid,
    input  logic         trace_ready,
    output logic [159:0] trace_data,
    output logic [63:0]  instret,
    output logic [63:0]  cycles,
    output logic [15:0]  drop_cnt,
    output logic         overflow,
    output logic         halted,
    output logic         timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUN, HALT_DRAIN, DONE, TIMEOUT} stateT;

    stateT          state, stateNext;
    logic [159:0]   mem [DEPTH];
    logic [AW-1:0]  rdPtr, wrPtr;
    // One extra bit so that a full FIFO (count == DEPTH) is just the MSB.
    logic [AW:0]    count, countNext;
    logic [WW-1:0]  wdCnt;
    logic           accept, pop, push, drop, full;

    always_comb begin
        accept    = commit && (state == RUN);
        full      = count[AW];
        pop       = (count != '0) && trace_ready;
        // A pop on the same edge frees the slot the push needs.
        push      = accept && (!full || pop);
        drop      = accept && full && !pop;
        countNext = count;
        if (push && !pop)
            countNext = count + 1'b1;
        else if (pop && !push)
            countNext = count - 1'b1;

        stateNext = state;
        case (state)
            RUN: begin
                if (accept && (commit_instr == HALT_INSTR))
                    stateNext = HALT_DRAIN;
                // A commit on the expiry edge keeps the run alive.
                else if (!commit && (wdCnt == WD_LAST))
                    stateNext = TIMEOUT;
            end
            HALT_DRAIN: begin
                if (countNext == '0)
                    stateNext = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            wdCnt    <= '0;
            instret  <= '0;
            cycles   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            if (accept)
                instret <= instret + 64'd1;
            if (state == RUN) begin
                cycles <= cycles + 64'd1;
                wdCnt  <= commit ? '0 : wdCnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Payload storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= {commit_instr, commit_pre_pc, commit_pc};
    end

    assign trace_valid = (count != '0);
    assign trace_data  = trace_valid ? mem[rdPtr] : '0;
    assign halted      = (state == DONE);
    assign timeout     = (state == TIMEOUT);

endmodule
